// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM port arbiter.
// DPRAM_ARB_RSPREG_EN adds a response register stage (read latency 3 instead of 2).
package dpram_arb_pkg;

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} lock_e;

`ifdef DPRAM_ARB_RSPREG_EN
  localparam int RD_LATENCY = 3;
`else
  localparam int RD_LATENCY = 2;
`endif

  // Wide enough for the largest supported requester count (8)
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             is_read;
  } tag_t;

endpackage

// File: rtl/dpram_r1w1_arbiter_rr_grant.sv
// Combinational round-robin picker: first set bit of valid at or after ptr.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int s;
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = 0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      j = IW'(s);
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_r1w1_arbiter.sv
// Round-robin arbiter with lock sharing one RAM port among NREQ requesters.
// DPRAM_ARB_RSPREG_EN registers rsp_valid/rsp_data after ram_read.
module dpram_r1w1_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int NREQ   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     ram_ce,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_write,
  input  logic [DATA_W-1:0]        ram_read
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lock_e           lock_st;
  logic [PW-1:0]   rr_ptr, lock_idx, gnt_idx, ptr_next;
  logic [NREQ-1:0] gnt_valid, gnt;
  logic            hs;

  logic              sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // While locked only the holder is visible to the picker
  always_comb begin
    gnt_valid = req_valid;
    if (lock_st == LOCKED) gnt_valid = req_valid & (NREQ'(1) << lock_idx);
  end

  rr_grant #(.N(NREQ), .IW(PW)) u_grant (
    .valid (gnt_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (hs)
  );

  assign req_ready = gnt;
  assign ptr_next  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      lock_st  <= OPEN;
      lock_idx <= '0;
    end else if (hs) begin
      if (sel_lock) begin
        lock_st  <= LOCKED;
        lock_idx <= gnt_idx;
      end else begin
        lock_st <= OPEN;
        rr_ptr  <= ptr_next;
      end
    end else if (lock_st == LOCKED && !req_valid[lock_idx]) begin
      lock_st <= OPEN;
    end
  end

  // tag_pipe[0] aligns with ram_* (N+1), tag_pipe[1] with ram_read (N+2)
  tag_t tag_pipe [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_write   <= '0;
      tag_pipe[0] <= '0;
      tag_pipe[1] <= '0;
    end else begin
      ram_ce <= hs;
      ram_we <= hs & sel_we;
      if (hs) begin
        ram_addr  <= sel_addr;
        ram_write <= sel_wdata;
      end
      tag_pipe[0] <= '{idx: IDX_W'(gnt_idx), is_read: hs & ~sel_we};
      tag_pipe[1] <= tag_pipe[0];
    end
  end

  logic [NREQ-1:0] rsp_hit;

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_hit[i] = tag_pipe[1].is_read && (tag_pipe[1].idx == IDX_W'(i));
  end

`ifdef DPRAM_ARB_RSPREG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_hit;
      rsp_data  <= ram_read;
    end
  end
`else
  assign rsp_valid = rsp_hit;
  assign rsp_data  = ram_read;
`endif

endmodule
